// File: rtl/seq_comparator.sv
// Digit-serial magnitude comparator: walks two WIDTH-bit operands MSB-first,
// DIGIT bits per clock, and reports a registered, one-hot G/E/L with a done pulse.
module seq_comparator #(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             G,
  output logic             E,
  output logic             L
);

  localparam int NUM_DIGITS = WIDTH / DIGIT;
  localparam int IDXW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  aOp_q, bOp_q;
  logic [IDXW-1:0]   idx_q;
  logic              haveVerdict_q;
  logic              verdictGt_q;

  logic [WIDTH-1:0]  aIn, bIn;
  logic [DIGIT-1:0]  digA, digB;
  logic              digitsDiffer, digitGt, lastDigit;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  always_comb begin
    aIn = A;
    bIn = B;
    aIn[WIDTH-1] = A[WIDTH-1] ^ signed_mode;
    bIn[WIDTH-1] = B[WIDTH-1] ^ signed_mode;
  end

  always_comb begin
    digA         = aOp_q[int'(idx_q) * DIGIT +: DIGIT];
    digB         = bOp_q[int'(idx_q) * DIGIT +: DIGIT];
    digitsDiffer = (digA != digB);
    digitGt      = (digA > digB);
    lastDigit    = (idx_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      aOp_q         <= '0;
      bOp_q         <= '0;
      idx_q         <= '0;
      haveVerdict_q <= 1'b0;
      verdictGt_q   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      G             <= 1'b0;
      E             <= 1'b0;
      L             <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            aOp_q         <= aIn;
            bOp_q         <= bIn;
            idx_q         <= IDXW'(NUM_DIGITS - 1);
            haveVerdict_q <= 1'b0;
            verdictGt_q   <= 1'b0;
            G             <= 1'b0;
            E             <= 1'b0;
            L             <= 1'b0;
            busy          <= 1'b1;
            state_q       <= RUN;
          end
        end
        RUN: begin
          if ((EARLY_EXIT != 0) && digitsDiffer) begin
            G       <= digitGt;
            L       <= !digitGt;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else if (lastDigit) begin
            // In constant-latency mode the earliest differing digit decides.
            if (haveVerdict_q) begin
              G <= verdictGt_q;
              L <= !verdictGt_q;
            end else if (digitsDiffer) begin
              G <= digitGt;
              L <= !digitGt;
            end else begin
              E <= 1'b1;
            end
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else begin
            if (digitsDiffer && !haveVerdict_q) begin
              haveVerdict_q <= 1'b1;
              verdictGt_q   <= digitGt;
            end
            idx_q <= idx_q - IDXW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
